fifo_umbrales: RTL and testbench
================================

# fifo_umbrales

Synchronous FIFO with programmable almost-full/almost-empty thresholds, instantiated once per Main, VC and D buffer of the switch datapath. It produces the per-FIFO `empty` and `error` bits that are concatenated into the control state machine's `FIFO_empties`/`FIFO_errors` buses. Its 2-bit thresholds are driven directly from that machine's latched `Umbrales_*_internos` outputs. Overflow and underflow are flagged as sticky errors that only reset clears.

## Interface
- `DATA_W`, default 6: word width (4 data bits + 2 class bits).
- `DEPTH`, default 8: number of entries; must be a power of two, 4 to 16.
- `ADDR_W`, default $clog2(DEPTH): pointer width; derived, do not override.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset (one clock; reset asynchronous and active-high).
- `push`  in  1  write request.
- `data_in`  in  DATA_W  write data, sampled when `push` is accepted.
- `pop`  in  1  read request.
- `umbral_alto`  in  2  almost-full margin, in free slots.
- `umbral_bajo`  in  2  almost-empty level, in occupied slots.
- `data_out`  out  DATA_W  read data.
- `valid_out`  out  1  `data_out` holds a popped word.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `full`, `empty`  out  1  `count==DEPTH` and `count==0` respectively.
- `almost_full`  out  1  `count >= DEPTH - umbral_alto`.
- `almost_empty`  out  1  `count <= umbral_bajo`.
- `error`  out  1  sticky overflow/underflow flag.

## Operation
- Storage uses a circular buffer with separate `wr_ptr`/`rd_ptr` (ADDR_W bits, wrap modulo DEPTH) and a `count` register.
- **Accepted push:** `push && (!full || pop)`. Writes `data_in` at `wr_ptr`; increments `wr_ptr`.
- **Accepted pop:** `pop && !empty`. Reads the entry at `rd_ptr`; increments `rd_ptr`.
- **Count update:** +1 on push only, -1 on pop only, unchanged when both push and pop are accepted in the same cycle.
- **Overflow:** `push && full && !pop`. Data is dropped, pointers are unchanged, `error` is set.
- **Underflow:** `pop && empty`. Nothing is read, `valid_out` stays 0, `error` is set. A simultaneous push in the same cycle is still accepted.
- **Error flag:** once set, `error` stays 1 until `reset`; normal push/pop keep operating meanwhile. The control machine then stays in ERROR until reset.
- **Thresholds:** comparisons are evaluated combinationally from `count` and the live threshold inputs; they are compared zero-extended to ADDR_W+1 bits. A threshold change takes effect on flags in the same cycle.
- **Threshold boundaries:**
  - `umbral_alto=0` makes `almost_full` equal `full`.
  - `umbral_bajo=0` makes `almost_empty` equal `empty`.

## Timing
- **Reset values:** pointers 0, `count` 0, `empty` 1, `almost_empty` 1, `full` 0, `almost_full` 0 (for DEPTH > 3), `error` 0, `valid_out` 0, `data_out` 0.
- **Reset mid-operation:** contents are discarded; every output returns to its reset value asynchronously.
- **Flags:** `count`, `full`, `empty`, `almost_*` and `error` reflect the edge on which the push/pop was sampled. They are visible one cycle after the request.
- **Default read latency:** `data_out` and `valid_out` are registered and appear one cycle after an accepted pop. `valid_out` is 1 for exactly one cycle per accepted pop. `data_out` holds its last value otherwise.
- **Back-to-back operation:** pops on consecutive cycles yield consecutive words with no bubbles. Push and pop in the same cycle on an empty FIFO is treated as underflow; the pushed word is not forwarded.

## Configuration
- **`FIFO_FWFT_EN` defined:** first-word fall-through mode.
  - `data_out` combinationally presents the entry at `rd_ptr`.
  - `valid_out = !empty`.
  - `pop` acknowledges the head word, with zero-cycle read latency.
  - `data_out` is don't-care while empty.
- **`FIFO_FWFT_EN` undefined:** registered one-cycle read latency, as described above.
- Flag, error and count behaviour is identical in both modes.

## Structure
- **Package `fifo_pkg`:** default `DATA_W`/`DEPTH` constants and the class-bit field positions. The widths of the `umbral_*` threshold type (2 bits) are also defined here and shared with the control machine.
- **Sub-module `mem_dp`:** DEPTH×DATA_W register array with one write port and one asynchronous read port, and no reset on contents. `fifo_umbrales` holds the pointers, count, flags and output register.

## Test plan
- **Reset, then 8 pushes of 0x01..0x08 (DEPTH=8, umbral_alto=2):** `almost_full` rises after the 6th push; `full` after the 8th; `error` stays 0.
- **Full FIFO, push 0x3F without pop:** `error`=1 and `count` stays 8. The subsequent 8 pops return 0x01..0x08, each with `valid_out` one cycle after its pop.
- **Empty FIFO, pop with push of 0x15:** `error`=1, `valid_out`=0 and `count`=1. The next pop returns 0x15.
- **Full FIFO, simultaneous push 0x2A and pop:** returns the head word, `count` stays 8, `error` stays 0. Pointers wrap past index 7 correctly.
- **umbral_bajo=3, drain from 5 to 0:** `almost_empty` rises when `count` reaches 3. Changing `umbral_bajo` to 0 drops `almost_empty` in the same cycle.
- **Assert reset with count=4 and error=1:** all outputs return to their reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the switch-datapath FIFOs and their control machine.
package fifo_pkg;

    localparam int DATA_W_DEF = 6;
    localparam int DEPTH_DEF  = 8;

    // Word layout: low nibble is payload, top two bits carry the traffic class.
    localparam int PAYLOAD_W = 4;
    localparam int CLASS_LSB = 4;
    localparam int CLASS_W   = 2;

    localparam int UMBRAL_W = 2;
    typedef logic [UMBRAL_W-1:0] umbral_t;

endpackage

// File: rtl/fifo_umbrales_if.sv
// Handshake, threshold and status bundle between a fifo_umbrales and its user.
interface fifo_umbrales_if #(
    parameter int DATA_W = fifo_pkg::DATA_W_DEF,
    parameter int DEPTH  = fifo_pkg::DEPTH_DEF
);
    import fifo_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    umbral_t           umbral_alto;
    umbral_t           umbral_bajo;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic              error;

    modport master (
        output push, data_in, pop, umbral_alto, umbral_bajo,
        input  data_out, valid_out, count, full, empty, almost_full, almost_empty, error
    );

    modport slave (
        input  push, data_in, pop, umbral_alto, umbral_bajo,
        output data_out, valid_out, count, full, empty, almost_full, almost_empty, error
    );

endinterface

// File: rtl/fifo_umbrales_mem_dp.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module mem_dp #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: contents are deliberately not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with almost-full/almost-empty thresholds and sticky overflow/underflow error.
// Define FIFO_FWFT_EN for first-word fall-through output; default is one-cycle registered read.
module fifo_umbrales
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    fifo_umbrales_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] rdata;

    logic full, empty;
    logic push_acc, pop_acc;
    logic overflow, underflow;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // A pop frees a slot on the same edge, so a full FIFO can still take a push alongside it.
    assign push_acc  = bus.push && (!full || bus.pop);
    assign pop_acc   = bus.pop && !empty;
    assign overflow  = bus.push && full && !bus.pop;
    assign underflow = bus.pop && empty;

    mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (push_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    // NOTE: every next-state signal gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        error_d  = error_q | overflow | underflow;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            error_q  <= error_d;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out  = rdata;
    assign bus.valid_out = !empty;
`else
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_out_q, valid_out_d;

    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = pop_acc;
        if (pop_acc) begin
            data_out_d = rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.error        = error_q;
    // Thresholds are zero-extended to the count width and take effect combinationally.
    assign bus.almost_full  = (count_q >= (DEPTH_C - (ADDR_W+1)'(bus.umbral_alto)));
    assign bus.almost_empty = (count_q <= (ADDR_W+1)'(bus.umbral_bajo));

endmodule

// File: tb/tb_fifo_umbrales.sv
// Scoreboard bench for fifo_umbrales: queue reference model, directed scenarios plus random traffic.
module tb_fifo_umbrales;
    import fifo_pkg::*;

    localparam int DW = 6;
    localparam int D  = 8;

    logic clk;
    logic reset;

    fifo_umbrales_if #(.DATA_W(DW), .DEPTH(D)) bus ();

    fifo_umbrales #(.DATA_W(DW), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            model_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic check_flags(input string tag);
        int c;
        c = model_q.size();
        check({tag, " count"}, 32'(bus.count), 32'(c));
        check({tag, " full"}, 32'(bus.full), 32'(c == D));
        check({tag, " empty"}, 32'(bus.empty), 32'(c == 0));
        check({tag, " almost_full"}, 32'(bus.almost_full), 32'(c >= D - int'(bus.umbral_alto)));
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'(c <= int'(bus.umbral_bajo)));
        check({tag, " error"}, 32'(bus.error), 32'(model_err));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " count"}, 32'(bus.count), 32'd0);
        check({tag, " empty"}, 32'(bus.empty), 32'd1);
        check({tag, " almost_empty"}, 32'(bus.almost_empty), 32'd1);
        check({tag, " full"}, 32'(bus.full), 32'd0);
        check({tag, " almost_full"}, 32'(bus.almost_full), 32'd0);
        check({tag, " error"}, 32'(bus.error), 32'd0);
        check({tag, " valid_out"}, 32'(bus.valid_out), 32'd0);
        check({tag, " data_out"}, 32'(bus.data_out), 32'd0);
    endtask

    // One clock of stimulus; the model applies the FIFO rules at the sampling edge.
    task automatic cycle(input bit p, input logic [DW-1:0] d, input bit r, input string tag);
        int c;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = r;
        @(posedge clk);
        c = model_q.size();
        if (r && c == 0) model_err = 1'b1;
        if (p && c == D && !r) model_err = 1'b1;
        if (r && c > 0) exp_q.push_back(model_q.pop_front());
        if (p && (c < D || r)) model_q.push_back(d);
        @(negedge clk);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        check_flags(tag);
    endtask

    // Asserted between edges so the asynchronous clear is observed before any clock.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values(tag);
        model_q.delete();
        exp_q.delete();
        model_err = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: every popped word must appear exactly one cycle later, nothing otherwise.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("valid_out on pop", 32'(bus.valid_out), 32'd1);
                check("data_out", 32'(bus.data_out), 32'(e));
            end else begin
                check("valid_out idle", 32'(bus.valid_out), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.push        = 1'b0;
        bus.pop         = 1'b0;
        bus.data_in     = '0;
        bus.umbral_alto = 2'd2;
        bus.umbral_bajo = 2'd1;
        model_err       = 1'b0;
        #1;
        check_reset_values("por");
        @(negedge clk);
        reset = 1'b0;

        // Fill: almost_full at 6, full at 8.
        for (int i = 1; i <= 8; i++) cycle(1'b1, DW'(i), 1'b0, "fill");

        // Full with simultaneous push/pop: no error, count stays 8.
        cycle(1'b1, 6'h2A, 1'b1, "full push+pop");

        // Overflow: data dropped, sticky error.
        cycle(1'b1, 6'h3F, 1'b0, "overflow");

        // Drain, including the wrap past index 7.
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "drain");

        // Underflow with push: error, nothing read, pushed word kept.
        cycle(1'b1, 6'h15, 1'b1, "underflow+push");
        cycle(1'b0, '0, 1'b1, "pop 0x15");

        // Almost-empty threshold, including a live threshold change.
        do_reset("reset1");
        bus.umbral_bajo = 2'd3;
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, "ae fill");
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "ae drain");
        bus.umbral_bajo = 2'd0;
        #1;
        check("live umbral_bajo=0 almost_empty", 32'(bus.almost_empty), 32'd0);
        bus.umbral_bajo = 2'd3;
        #1;
        check("live umbral_bajo=3 almost_empty", 32'(bus.almost_empty), 32'd1);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, "ae drain");

        // umbral_alto=0 makes almost_full track full.
        bus.umbral_alto = 2'd0;
        for (int i = 0; i < 8; i++) cycle(1'b1, DW'(i + 5), 1'b0, "af0 fill");
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "af0 drain");

        // Randomised traffic with biased fill/drain phases and changing thresholds.
        do_reset("reset2");
        for (int i = 0; i < 400; i++) begin
            bit p, r;
            if ($urandom_range(0, 7) == 0) begin
                bus.umbral_alto = umbral_t'($urandom_range(0, 3));
                bus.umbral_bajo = umbral_t'($urandom_range(0, 3));
            end
            if ((i / 40) % 2 == 0) begin
                p = ($urandom_range(0, 9) < 7);
                r = ($urandom_range(0, 9) < 3);
            end else begin
                p = ($urandom_range(0, 9) < 3);
                r = ($urandom_range(0, 9) < 7);
            end
            cycle(p, DW'($urandom_range(0, 63)), r, "random");
        end

        // Reset mid-operation with count=4 and error=1.
        do_reset("reset3");
        cycle(1'b1, 6'h11, 1'b1, "mid underflow");
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h31 + i), 1'b0, "mid fill");
        do_reset("async reset mid-op");
        cycle(1'b0, '0, 1'b0, "post reset idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
